// File: rtl/m31_pkg.sv
// Mersenne-31 field types and the shared modular add/double helpers used by
// every linear-layer block of the permutation core.
package m31_pkg;

  typedef logic [30:0] m31_t;

  localparam m31_t P_M31 = 31'h7FFF_FFFF;

  // a + b mod P for canonical operands: 32-bit sum, end-around carry fold,
  // then the lone non-canonical result P is mapped to 0.
  function automatic m31_t m31_add(input m31_t a, input m31_t b);
    logic [31:0] sum;
    m31_t        fold;
    sum  = {1'b0, a} + {1'b0, b};
    // With canonical inputs sum <= 2^32 - 4, so this fold cannot carry out.
    fold = sum[30:0] + 31'(sum[31]);
    return (fold == P_M31) ? '0 : fold;
  endfunction

  // 2a mod P is a rotate-left-by-1 because 2^31 == 1 mod P.
  function automatic m31_t m31_dbl(input m31_t a);
    return {a[29:0], a[30]};
  endfunction

endpackage

// File: rtl/m31_m4.sv
// Combinational 4x4 M4 matrix (rows [2 3 1 1] [1 2 3 1] [1 1 2 3] [3 1 1 2])
// evaluated with the shared add/double chain.
module m31_m4
  import m31_pkg::*;
(
  input  m31_t [3:0] in,
  output m31_t [3:0] out
);

  m31_t t01, t23, t0123, t01123, t01233;

  // Add/double chain: five shared partial sums feed the four outputs.
  always_comb begin
    t01    = m31_add(in[0], in[1]);
    t23    = m31_add(in[2], in[3]);
    t0123  = m31_add(t01, t23);
    t01123 = m31_add(t0123, in[1]);
    t01233 = m31_add(t0123, in[3]);
    out[0] = m31_add(t01123, t01);
    out[1] = m31_add(t01123, m31_dbl(in[2]));
    out[2] = m31_add(t01233, t23);
    out[3] = m31_add(t01233, m31_dbl(in[0]));
  end

endmodule

// File: rtl/m31_mds_ext.sv
// Poseidon2 external linear layer over M31: per-chunk M4 (stage 1), then the
// circulant circ(2*M4, M4, ..., M4) mix (stage 2). Two-stage pipeline.
//
// Handshake: a vector moves across an interface on a clock edge where both
// valid and ready are high. A stage advances when it is empty or the stage
// after it advances; a stage that does not advance holds data and valid bit.
// in_ready depends only on out_ready and the internal valid bits, never on
// in_valid.
module m31_mds_ext
  import m31_pkg::*;
#(
  parameter int T = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  m31_t [T-1:0]   in_state,
  output logic           out_valid,
  input  logic           out_ready,
  output m31_t [T-1:0]   out_state
);

  localparam int K      = T / 4;
  localparam int LEVELS = $clog2(K);

  if ((T % 4 != 0) || (T < 4) || (T > 24)) begin : g_bad_t
    $error("m31_mds_ext: T must be a multiple of 4 in the range 4..24");
  end

  logic           v1, v2, adv1, adv2;
  m31_t [T-1:0]   m4_out;
  m31_t [T-1:0]   u_q;
  m31_t [T-1:0]   y;
  m31_t [2*K-1:0] tree;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  // Stage 1: one M4 block per 4-lane chunk.
  for (genvar c = 0; c < K; c++) begin : g_m4
    m31_m4 u_m4 (
      .in  (in_state[4*c +: 4]),
      .out (m4_out[4*c +: 4])
    );
  end

  // Stage 1 valid bit: cleared by reset so in-flight vectors are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) v1 <= 1'b0;
    else if (adv1) v1 <= in_valid;
  end

  // Stage 1 data: no reset needed, qualified by v1.
  always_ff @(posedge clk) begin
    if (adv1) u_q <= m4_out;
  end

  // Stage 2 combinational mix: per lane a balanced pairwise tree sums the
  // chunks, each chunk then adds that lane sum to itself. K == 1 is a pass.
  always_comb begin
    tree = '0;
    y    = '0;
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < K; c++) tree[c] = u_q[4*c+j];
      for (int l = 0; l < LEVELS; l++) begin
        for (int i = 0; i < K; i++) begin
          // cnt at this level is ceil(K / 2^l); odd leftovers carry upward.
          if (2*i + 1 < ((K + (1 << l) - 1) >> l))
            tree[i] = m31_add(tree[2*i], tree[2*i+1]);
          else if (2*i < ((K + (1 << l) - 1) >> l))
            tree[i] = tree[2*i];
        end
      end
      for (int c = 0; c < K; c++)
        y[4*c+j] = (K == 1) ? u_q[4*c+j] : m31_add(u_q[4*c+j], tree[0]);
    end
  end

  // Stage 2 registers: output valid and result, both reset to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      out_state <= '0;
    end else if (adv2) begin
      v2        <= v1;
      out_state <= y;
    end
  end

endmodule

// File: tb/tb_m31_mds_ext.sv
// Bench for m31_mds_ext (T = 16): directed vectors, a back-to-back random
// stream, random backpressure and a mid-flight reset, checked against a
// plain-arithmetic model of circ(2*M4, M4, ...) * x mod P.
module tb_m31_mds_ext;
  import m31_pkg::*;

  localparam int     T  = 16;
  localparam int     K  = T / 4;
  localparam int     W  = T * 31;
  localparam longint PL = 64'd2147483647;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  m31_t [T-1:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  m31_t [T-1:0] out_state;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           out_cnt = 0;
  int           cyc = 0;
  bit           rand_ready = 1'b0;
  logic [W-1:0] exp_q[$];
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d = '0;

  int m4_tab [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  m31_mds_ext #(.T(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_mds(input logic [W-1:0] x);
    longint       u [T];
    longint       acc;
    logic [W-1:0] y;
    y = '0;
    for (int c = 0; c < K; c++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc += longint'(m4_tab[j][k]) * longint'(x[(4*c+k)*31 +: 31]);
        u[4*c+j] = acc % PL;
      end
    for (int c = 0; c < K; c++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int d = 0; d < K; d++)
          acc += ((c == d) ? 2 : 1) * u[4*d+j];
        y[(4*c+j)*31 +: 31] = 31'(acc % PL);
      end
    return y;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < T; i++) begin
      case ($urandom_range(0, 7))
        0:       v[i*31 +: 31] = 31'h7FFF_FFFE;
        1:       v[i*31 +: 31] = '0;
        default: v[i*31 +: 31] = 31'($urandom_range(0, 32'h7FFF_FFFE));
      endcase
    end
    return v;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        n_cmp++;
        assert (out_valid === 1'b1 && out_state === hold_d) else begin
          n_bad++;
          $error("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, out_state, hold_d);
        end
      end
      n_cmp++;
      assert (in_ready === !(exp_q.size() == 2 && !out_ready)) else begin
        n_bad++;
        $error("FAIL in_ready: got %b want %b (occupancy %0d)", in_ready,
               !(exp_q.size() == 2 && !out_ready), exp_q.size());
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_bad++;
          $error("FAIL spurious_out: got %h want no output", out_state);
        end
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          n_cmp++;
          assert (out_state === exp_v) else begin
            n_bad++;
            $error("FAIL out_state: got %h want %h", out_state, exp_v);
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_state;
      if (in_valid && in_ready) exp_q.push_back(ref_mds(in_state));
    end
  end

  // Random backpressure, changed just after each rising edge when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Present v until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [W-1:0] v);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_state = v;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    assert (budget < 200) else begin
      n_bad++;
      $error("FAIL send_timeout: got %0d cycles want < 200", budget);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] v, want;
    int c0, t0, budget;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", W'(out_valid), W'(1'b0));
    check("reset_out_state", out_state, '0);
    check("reset_in_ready", W'(in_ready), W'(1'b1));
    idle_cycle();

    // [1,2,3,4,0,...]: chunk 0 gets 2*M4*x, the other chunks M4*x
    out_ready = 1'b1;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*31 +: 31] = 31'(i + 1);
    want = '0;
    for (int c = 0; c < K; c++) begin
      want[(4*c+0)*31 +: 31] = (c == 0) ? 31'd30 : 31'd15;
      want[(4*c+1)*31 +: 31] = (c == 0) ? 31'd36 : 31'd18;
      want[(4*c+2)*31 +: 31] = (c == 0) ? 31'd42 : 31'd21;
      want[(4*c+3)*31 +: 31] = (c == 0) ? 31'd32 : 31'd16;
    end
    send(v);
    @(negedge clk);
    check("latency_not_early", W'(out_valid), W'(1'b0));
    @(negedge clk);
    check("latency_valid", W'(out_valid), W'(1'b1));
    check("dir_1234", out_state, want);
    idle_cycle();
    idle_cycle();

    // All lanes P-1: 5 * (-7) mod P = P - 35 in every lane
    for (int i = 0; i < T; i++) v[i*31 +: 31] = 31'h7FFF_FFFE;
    for (int i = 0; i < T; i++) want[i*31 +: 31] = 31'd2147483612;
    send(v);
    @(negedge clk);
    @(negedge clk);
    check("dir_all_pm1", out_state, want);
    idle_cycle();
    idle_cycle();

    // 100 back-to-back random vectors: no bubbles
    c0 = out_cnt;
    t0 = cyc;
    for (int n = 0; n < 100; n++) send(rand_vec());
    check("stream_cycles", W'(cyc - t0), W'(100));
    repeat (2) @(posedge clk);
    #1;
    check("stream_outputs", W'(out_cnt - c0), W'(100));

    // Random in_valid with random out_ready
    rand_ready = 1'b1;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 1) == 1) send(rand_vec());
      else idle_cycle();
    end
    rand_ready = 1'b0;
    idle_cycle();
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      idle_cycle();
      budget++;
    end
    check("drain_empty", W'(exp_q.size()), W'(0));
    idle_cycle();

    // Reset with two vectors in flight
    out_ready = 1'b0;
    send(rand_vec());
    send(rand_vec());
    @(negedge clk);
    check("full_in_ready", W'(in_ready), W'(1'b0));
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    c0 = out_cnt;
    @(negedge clk);
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_out_state", out_state, '0);
    check("rst_in_ready", W'(in_ready), W'(1'b1));
    repeat (5) idle_cycle();
    check("rst_no_emit", W'(out_cnt - c0), W'(0));

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m31_mds_ext.md
# m31_mds_ext

Parametrised, pipelined Poseidon2 external linear layer over the Mersenne-31 field (P = 2^31 − 1) for state width T = 4·K. Each 4-lane chunk passes through the fixed 4×4 matrix M4, then the circulant mix circ(2·M4, M4, …, M4) is applied, with a valid/ready handshake and full throughput. It sits between the S-box stage and the round-constant adder in the full-round datapath of the permutation core.

## Interface
- T, default 16: state width in lanes; legal values 4, 8, 12, 16, 20, 24 (multiple of 4); K = T/4 chunks.
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_state is valid this cycle.
- in_ready  output  1  block accepts in_state this cycle.
- in_state  input  T×31 (m31_t [T-1:0])  input vector; lanes canonical in [0, P−1].
- out_valid  output  1  out_state holds a result.
- out_ready  input  1  downstream accepts out_state this cycle.
- out_state  output  T×31 (m31_t [T-1:0])  result vector, always canonical.

## Operation
- M4 rows: [2 3 1 1], [1 2 3 1], [1 1 2 3], [3 1 1 2]. Chunk c covers lanes 4c..4c+3.
- Stage 1: u_c = M4 · x_c for every chunk c, computed by the add/double chain: t01 = x0+x1, t23 = x2+x3, t0123 = t01+t23, t01123 = t0123+x1, t01233 = t0123+x3; u0 = t01123+t01, u1 = t01123+2x2, u2 = t01233+t23, u3 = t01233+2x0. Result registered.
- Stage 2: for each lane j in 0..3, s_j = Σ_c u_c[j] via a balanced modular adder tree of depth ceil(log2 K); y_c[j] = u_c[j] + s_j. Result registered into out_state.
- T = 4 (K = 1): stage 2 passes u unchanged (y = M4·x); the stage is still present.
- Arithmetic: every add is 32-bit sum, end-around carry fold, and a final map of P to 0; doubling is a 31-bit rotate-left-by-1. No intermediate value exceeds 31 bits. Non-canonical input (lane = P) is out of contract.
- Handshake: a transfer happens on a cycle where valid and ready are both high. Stage advance rules: adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1.
- On adv1: v1 <= in_valid, u <= M4(in_state). On adv2: v2 <= v1, out_state <= y(u). A stage that does not advance holds its data and valid bit.
- out_state and out_valid stay stable while out_valid & !out_ready.
- Reset: v1 = v2 = 0, out_valid = 0, out_state = 0, in_ready = 1 on the first cycle after reset. Reset mid-operation discards all in-flight vectors without producing output. Stage-1 data registers do not need reset.

## Timing
- Latency: 2 cycles from the accepting edge to out_valid, with out_ready held high.
- Throughput: 1 vector per cycle while out_ready = 1; a back-to-back stream produces no bubbles.
- in_ready is combinational from out_ready (one AND-OR level), and has no path from in_valid.
- Stall: with out_ready = 0, the pipeline fills to 2 vectors, then in_ready drops in the same cycle. When out_ready rises, in_ready rises in that same cycle.
- Critical path: stage 2 for T = 24, with 3 tree adds and 1 final add.

## Structure
- m31_pkg holds m31_t, P_M31, and the shared functions m31_add and m31_dbl. These are moved there from local functions so every linear-layer block uses one implementation.
- Sub-module m31_m4, combinational only: m31_t [3:0] in, m31_t [3:0] out. It is instantiated K times in stage 1 via generate.
- The generate-time assertion fails if T % 4 != 0, T < 4 or T > 24.

## Test plan
- T = 4, in_state = [1, 2, 3, 4] (lane 0 first) -> after 2 cycles out_state = [15, 18, 21, 16].
- T = 8, in_state = [1, 2, 3, 4, 0, 0, 0, 0] -> out_state = [30, 36, 42, 32, 15, 18, 21, 16].
- T = 8, all lanes P−1 = 2147483646 -> every lane 2147483626 (P−21), which exercises the carry fold. For T = 4, all lanes P−1 -> every lane 2147483640.
- T = 16, a stream of 100 back-to-back random vectors with out_ready = 1 -> 100 outputs in order, no gaps, matching a reference model of circ(2·M4, M4, …)·x mod P.
- Random out_ready (50%) with random in_valid -> no loss, duplication or reordering; out_state is stable during stalls; in_ready = 0 only when both stages are full and out_ready = 0.
- Assert rst_n for 1 cycle with 2 vectors in flight -> next cycle out_valid = 0, out_state = 0, in_ready = 1, and those vectors are never emitted.
